// File: rtl/gpr_file_sb.sv
// Parametrised GPR file with per-register busy scoreboard and RAW/WAW issue gating.
// Optional same-cycle writeback forwarding when GPR_WB_BYPASS_EN is defined.
module gpr_file_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         rd_addr_1,
  input  logic                      rd_use_1,
  output logic [DATA_W-1:0]         rd_data_1,
  input  logic [ADDR_W-1:0]         rd_addr_2,
  input  logic                      rd_use_2,
  output logic [DATA_W-1:0]         rd_data_2,
  input  logic                      iss_valid,
  input  logic                      iss_wr,
  input  logic [ADDR_W-1:0]         iss_dest,
  output logic                      iss_ready,
  input  logic                      wb_en,
  input  logic [ADDR_W-1:0]         wb_dest,
  input  logic [DATA_W-1:0]         wb_data,
  output logic [(2**ADDR_W)-1:0]    busy_vec,
  output logic                      busy_any
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic              r_busy_any;

  logic              w_wb_ok;
  logic              w_set;
  logic [NREGS-1:0]  w_wb_hit;
  logic [NREGS-1:0]  w_eff_busy;
  logic [NREGS-1:0]  w_busy_nxt;
  logic              w_raw1;
  logic              w_raw2;
  logic              w_waw;

  // Register 0 is inert (never written, never busy) when hardwired to zero.
  assign w_wb_ok  = wb_en & ~(ZERO_REG && (wb_dest == '0));
  assign w_wb_hit = w_wb_ok ? (NREGS'(1) << wb_dest) : '0;

`ifdef GPR_WB_BYPASS_EN
  assign w_eff_busy = r_busy & ~w_wb_hit;
`else
  assign w_eff_busy = r_busy;
`endif

  assign w_raw1    = rd_use_1 & w_eff_busy[rd_addr_1];
  assign w_raw2    = rd_use_2 & w_eff_busy[rd_addr_2];
  assign w_waw     = iss_wr   & w_eff_busy[iss_dest];
  assign iss_ready = ~(w_raw1 | w_raw2 | w_waw);

  assign w_set = iss_valid & iss_ready & iss_wr & ~(ZERO_REG && (iss_dest == '0));

  // A new producer issued in the writeback cycle keeps ownership of the register.
  always_comb begin
    w_busy_nxt = r_busy & ~w_wb_hit;
    if (w_set) begin
      w_busy_nxt[iss_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy     <= '0;
      r_busy_any <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_any <= |w_busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_ok) begin
      r_regs[wb_dest] <= wb_data;
    end
  end

  always_comb begin
    rd_data_1 = r_regs[rd_addr_1];
    if (ZERO_REG && (rd_addr_1 == '0)) begin
      rd_data_1 = '0;
    end
`ifdef GPR_WB_BYPASS_EN
    if (w_wb_ok && (wb_dest == rd_addr_1)) begin
      rd_data_1 = wb_data;
    end
`endif
  end

  always_comb begin
    rd_data_2 = r_regs[rd_addr_2];
    if (ZERO_REG && (rd_addr_2 == '0)) begin
      rd_data_2 = '0;
    end
`ifdef GPR_WB_BYPASS_EN
    if (w_wb_ok && (wb_dest == rd_addr_2)) begin
      rd_data_2 = wb_data;
    end
`endif
  end

  assign busy_vec = r_busy;
  assign busy_any = r_busy_any;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: two instances (ZERO_REG 0/1) on shared stimulus,
// directed scenarios plus random traffic against an array-based reference model.
module tb_gpr_file_sb;

`ifdef GPR_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  rd_addr_1, rd_addr_2, iss_dest, wb_dest;
  logic        rd_use_1, rd_use_2, iss_valid, iss_wr, wb_en;
  logic [15:0] wb_data;

  logic [15:0] rd1 [2];
  logic [15:0] rd2 [2];
  logic        rdy [2];
  logic [7:0]  bv  [2];
  logic        bany[2];

  logic [15:0] m_reg  [2][8];
  bit          m_busy [2][8];

  int n_cmp = 0;
  int n_err = 0;

  gpr_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .rd_addr_1(rd_addr_1), .rd_use_1(rd_use_1), .rd_data_1(rd1[0]),
    .rd_addr_2(rd_addr_2), .rd_use_2(rd_use_2), .rd_data_2(rd2[0]),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dest(iss_dest), .iss_ready(rdy[0]),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .busy_vec(bv[0]), .busy_any(bany[0])
  );

  gpr_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .rd_addr_1(rd_addr_1), .rd_use_1(rd_use_1), .rd_data_1(rd1[1]),
    .rd_addr_2(rd_addr_2), .rd_use_2(rd_use_2), .rd_data_2(rd2[1]),
    .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dest(iss_dest), .iss_ready(rdy[1]),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .busy_vec(bv[1]), .busy_any(bany[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural rules evaluated with plain array lookups.
  function automatic logic [15:0] exp_rd(int z, logic [2:0] a);
    if (z == 1 && a == 3'd0) return 16'h0;
    if (BYP && wb_en && !(z == 1 && wb_dest == 3'd0) && wb_dest == a) return wb_data;
    return m_reg[z][a];
  endfunction

  function automatic bit eff_busy(int z, logic [2:0] r);
    if (BYP && wb_en && wb_dest == r) return 1'b0;
    return m_busy[z][r];
  endfunction

  function automatic bit exp_ready(int z);
    bit hz;
    hz = (rd_use_1 && eff_busy(z, rd_addr_1)) || (rd_use_2 && eff_busy(z, rd_addr_2)) ||
         (iss_wr && eff_busy(z, iss_dest));
    return !hz;
  endfunction

  function automatic logic [7:0] exp_bv(int z);
    logic [7:0] v;
    for (int r = 0; r < 8; r++) v[r] = m_busy[z][r];
    return v;
  endfunction

  task automatic compare_model();
    for (int z = 0; z < 2; z++) begin
      check_eq($sformatf("z%0d_rd1", z), 32'(rd1[z]), 32'(exp_rd(z, rd_addr_1)));
      check_eq($sformatf("z%0d_rd2", z), 32'(rd2[z]), 32'(exp_rd(z, rd_addr_2)));
      check_eq($sformatf("z%0d_ready", z), 32'(rdy[z]), 32'(exp_ready(z)));
      check_eq($sformatf("z%0d_busy_vec", z), 32'(bv[z]), 32'(exp_bv(z)));
      check_eq($sformatf("z%0d_busy_any", z), 32'(bany[z]), 32'(exp_bv(z) != 8'h00));
    end
  endtask

  task automatic model_update();
    bit acc [2];
    for (int z = 0; z < 2; z++) acc[z] = iss_valid && exp_ready(z);
    for (int z = 0; z < 2; z++) begin
      if (!reset) begin
        for (int r = 0; r < 8; r++) begin
          m_reg[z][r]  = 16'h0;
          m_busy[z][r] = 1'b0;
        end
      end else begin
        if (wb_en && !(z == 1 && wb_dest == 3'd0)) begin
          m_reg[z][wb_dest]  = wb_data;
          m_busy[z][wb_dest] = 1'b0;
        end
        if (acc[z] && iss_wr && !(z == 1 && iss_dest == 3'd0)) m_busy[z][iss_dest] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    reset = 1'b1; rd_addr_1 = 3'd0; rd_addr_2 = 3'd0; rd_use_1 = 1'b0; rd_use_2 = 1'b0;
    iss_valid = 1'b0; iss_wr = 1'b0; iss_dest = 3'd0; wb_en = 1'b0; wb_dest = 3'd0;
    wb_data = 16'h0;
  endtask

  task automatic settle();
    #1;
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    for (int z = 0; z < 2; z++)
      for (int r = 0; r < 8; r++) begin
        m_reg[z][r] = 16'hxxxx; m_busy[z][r] = 1'b0;
      end
    idle();
    @(negedge clk);

    // Reset with a coincident writeback that must be ignored.
    reset = 1'b0; wb_en = 1'b1; wb_dest = 3'd3; wb_data = 16'hBEEF;
    @(posedge clk); model_update(); @(negedge clk);
    tick();
    idle(); rd_addr_1 = 3'd3; rd_addr_2 = 3'd3; settle();
    check_eq("rst_rd1", 32'(rd1[0]), 32'h0);
    check_eq("rst_busy", 32'(bv[0]), 32'h00);
    check_eq("rst_ready", 32'(rdy[0]), 32'h1);
    check_eq("rst_any", 32'(bany[0]), 32'h0);
    tick();

    // RAW on r5.
    idle(); iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 3'd5; settle(); tick();
    idle(); rd_addr_1 = 3'd5; rd_use_1 = 1'b1; settle();
    check_eq("raw_stall", 32'(rdy[0]), 32'h0);
    check_eq("raw_busy", 32'(bv[0]), 32'h20);
    tick();
    wb_en = 1'b1; wb_dest = 3'd5; wb_data = 16'h1234; settle();
    check_eq("raw_wb_ready", 32'(rdy[0]), 32'(BYP));
    if (BYP) check_eq("raw_wb_fwd", 32'(rd1[0]), 32'h1234);
    tick();
    idle(); rd_addr_1 = 3'd5; rd_use_1 = 1'b1; settle();
    check_eq("raw_after_ready", 32'(rdy[0]), 32'h1);
    check_eq("raw_after_rd1", 32'(rd1[0]), 32'h1234);
    tick();

    // WAW on r2.
    idle(); iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 3'd2; settle(); tick();
    settle();
    check_eq("waw_stall", 32'(rdy[0]), 32'h0);
    check_eq("waw_busy", 32'(bv[0]), 32'h04);
    tick();
    idle(); settle();
    check_eq("waw_hold", 32'(bv[0]), 32'h04);
    tick();
    wb_en = 1'b1; wb_dest = 3'd2; wb_data = 16'h2222; settle(); tick();
    idle(); settle();
    check_eq("waw_clear", 32'(bv[0]), 32'h00);
    tick();

    // Simultaneous issue and writeback on r4.
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 3'd4; settle(); tick();
    wb_en = 1'b1; wb_dest = 3'd4; wb_data = 16'h4444; settle(); tick();
    idle(); rd_addr_2 = 3'd4; settle();
    check_eq("sim_rd2", 32'(rd2[0]), 32'h4444);
    check_eq("sim_busy4", 32'(bv[0][4]), 32'(BYP));
    tick();

    // Hardwired zero register (instance 1).
    reset = 1'b0; settle(); tick();
    idle(); wb_en = 1'b1; wb_dest = 3'd0; wb_data = 16'hFFFF; settle(); tick();
    idle(); settle();
    check_eq("z_rd_r0", 32'(rd1[1]), 32'h0);
    check_eq("nz_rd_r0", 32'(rd1[0]), 32'hFFFF);
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 3'd0; settle();
    check_eq("z_iss0_ready", 32'(rdy[1]), 32'h1);
    tick();
    idle(); iss_wr = 1'b1; iss_dest = 3'd0; settle();
    check_eq("z_iss0_busy", 32'(bv[1]), 32'h00);
    check_eq("z_iss0_waw", 32'(rdy[1]), 32'h1);
    tick();

    // Unused source does not stall.
    idle(); iss_valid = 1'b1; iss_wr = 1'b1; iss_dest = 3'd6; settle(); tick();
    idle(); rd_addr_2 = 3'd6; rd_use_2 = 1'b0; settle();
    check_eq("unused_src", 32'(rdy[0]), 32'h1);
    rd_use_2 = 1'b1; #1;
    check_eq("used_src", 32'(rdy[0]), 32'h0);
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) != 0);
      rd_addr_1 = 3'($urandom_range(0, 7));
      rd_addr_2 = 3'($urandom_range(0, 7));
      rd_use_1  = 1'($urandom_range(0, 1));
      rd_use_2  = 1'($urandom_range(0, 1));
      iss_valid = 1'($urandom_range(0, 1));
      iss_wr    = ($urandom_range(0, 9) < 7);
      iss_dest  = 3'($urandom_range(0, 7));
      wb_en     = ($urandom_range(0, 9) < 4);
      wb_dest   = 3'($urandom_range(0, 7));
      wb_data   = 16'($urandom);
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
